// File: rtl/lsu_axi_master.sv
// lsu_axi_master
// AXI-lite initiator for the load/store unit. Takes one load or store request
// at a time, runs the matching AR/R or AW/W/B transaction, and returns
// extended load data or a store completion on a valid/ready response port.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_we, req_addr,         store flag, byte address,
//   req_wdata, req_size,      right-justified store data, size (byte/half/word),
//   req_unsigned              zero-extend loads when set
//   resp_valid/resp_ready     response handshake
//   resp_rdata, resp_err      extended load data (0 for stores/errors), error flag
//   ar*/r*                    AXI-lite read address / read data channels
//   aw*/w*/b*                 AXI-lite write address / write data / write response
//
// State | meaning
// IDLE    | waiting for a request, req_ready high
// RD_ADDR | arvalid high until arready
// RD_DATA | rready high until rvalid
// WR_REQ  | awvalid/wvalid high, each dropped after its own handshake
// WR_RESP | bready high until bvalid
// DONE    | resp_valid high until resp_ready

module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,

    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,

    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t      state;
    logic        aw_done;
    logic        w_done;
    logic [1:0]  addr_lo;
    logic [1:0]  size_q;
    logic        uns_q;

    logic        misaligned;
    logic [3:0]  strb_base;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] load_ext;
    logic        aw_hs;
    logic        w_hs;

    always_comb begin
        strb_base  = 4'b0000;
        misaligned = 1'b0;
        case (req_size)
            2'b00: strb_base = 4'b0001;
            2'b01: begin
                strb_base  = 4'b0011;
                misaligned = req_addr[0];
            end
            2'b10: begin
                strb_base  = 4'b1111;
                misaligned = |req_addr[1:0];
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Bring the addressed byte/half down to bit 0 before extension.
    assign lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_ext = lane;
        case (size_q)
            2'b00: load_ext = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01: load_ext = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= '0;
            awvalid    <= 1'b0;
            wdata      <= '0;
            wstrb      <= 4'b0000;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            addr_lo    <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr_lo   <= req_addr[1:0];
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        if (misaligned) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= DONE;
                        end else if (!req_we) begin
                            araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            arvalid <= 1'b1;
                            state   <= RD_ADDR;
                        end else begin
                            awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            wdata   <= req_wdata << {req_addr[1:0], 3'b000};
                            wstrb   <= strb_base << req_addr[1:0];
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= WR_REQ;
                        end
                    end
                end

                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_err   <= |rresp;
                        // Error responses carry no data back to the core.
                        resp_rdata <= (|rresp) ? '0 : load_ext;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end

                WR_REQ: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // Either channel may finish first or both in the same cycle.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_err   <= |bresp;
                        resp_rdata <= '0;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end

                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- AXI-lite master (initiator) for the core's load/store unit; the other end of the data-SRAM slave.
- Accepts one load or store request at a time from the memory stage and runs the matching AXI-lite transaction on AR/R or AW/W/B.
- Returns load data aligned and sign/zero-extended, or a store completion, through a valid/ready response port.
- Placed between the LSU stage and the data-memory AXI-lite slave (or the arbiter in front of it).

Parameters:
- ADDR_W, 32, AXI and request address width.
- DATA_W, 32, AXI data width. Fixed at 32: byte lanes and wstrb are 4 bits.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified (byte/half in the low bits).
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned/illegal request, or nonzero rresp/bresp.
- araddr  out  ADDR_W
- arvalid  out  1
- arready  in  1
- rdata  in  DATA_W
- rresp  in  2
- rvalid  in  1
- rready  out  1
- awaddr  out  ADDR_W
- awvalid  out  1
- awready  in  1
- wdata  out  DATA_W
- wstrb  out  4
- wvalid  out  1
- wready  in  1
- bresp  in  2
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset: state IDLE. All valid/ready outputs 0 except req_ready = 1. resp_rdata = 0, resp_err = 0, araddr/awaddr/wdata = 0, wstrb = 0.
- Reset mid-transaction abandons it. All AXI valids are low from the next edge; no response is produced.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE, on req_valid & req_ready: latch the request.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11: go to DONE with resp_err = 1 and no AXI traffic.
  - Else a load goes to RD_ADDR; a store goes to WR_REQ.
- Addresses: araddr = awaddr = {addr[ADDR_W-1:2], 2'b00}.
- Store lanes: wdata = req_wdata << (8*addr[1:0]). wstrb = 0001/0011/1111 for byte/half/word, shifted left by addr[1:0].
- RD_ADDR: arvalid = 1, araddr stable. On arready go to RD_DATA.
- RD_DATA: rready = 1. On rvalid:
  - Select lane (rdata >> 8*addr[1:0]).
  - Extend per size and req_unsigned.
  - Latch into resp_rdata; resp_err = (rresp != 0).
  - Go to DONE.
- WR_REQ: awvalid and wvalid both assert on entry.
  - Each drops independently after its handshake, tracked by aw_done/w_done flags.
  - AW and W may complete in either order or the same cycle.
  - W must stay valid while the slave withholds wready until after AW.
  - When both are done (flags or current-cycle handshakes), go to WR_RESP.
- WR_RESP: bready = 1. On bvalid: resp_err = (bresp != 0), resp_rdata = 0, go to DONE.
- DONE: resp_valid = 1, outputs stable. On resp_ready go to IDLE.
- Single outstanding request; no pipelining. req_ready is 0 outside IDLE.
- AXI rules:
  - A valid, once high, stays high with stable payload until its handshake.
  - Valids and readies derive only from state/flags; no combinational path from any AXI input to any AXI output.
- Latency with zero-wait slave responses: load accepted at cycle 0 → arvalid at 1 → rready at 2 → resp_valid at 3 at the earliest. Stores are the same.
- Total latency = 3 + slave wait cycles.

Test Plan:
- Word load, addr 0x80000004, slave returns 0xDEADBEEF after 3 waits → araddr = 0x80000004; resp_rdata = 0xDEADBEEF, resp_err = 0.
- Byte load signed, addr 0x80000003, rdata 0x80FF7F01 → resp_rdata = 0xFFFFFF80. Same load unsigned → 0x00000080. Half load signed at 0x80000002 → 0xFFFF80FF.
- Byte store 0x000000AB to 0x80000001 → awaddr = 0x80000000, wdata = 0x0000AB00, wstrb = 0010. Slave gives wready 2 cycles after awready; wvalid is held throughout; one resp_valid.
- Half store at 0x80000003 → resp_err = 1, resp_rdata = 0 at cycle 1, no arvalid/awvalid ever asserted.
- Load with rresp = 2'b10 → resp_err = 1. resp_ready held low 4 cycles → resp_valid and data stable; req_ready = 0 until the accept.
- rst asserted while in RD_DATA → next cycle arvalid = rready = resp_valid = 0, req_ready = 1; a following word store completes normally.
